uart_rx_cfg: RTL
================

# uart_rx_cfg

Parametrised UART receiver, the next generation of the fixed 8N1 `uart_rx`. It adds configurable data width, parity and stop bits, and 16x oversampling with 3-sample majority voting. It also detects false starts, parity errors, framing errors and break conditions, and presents received characters on a valid/ready output with a sticky overrun flag. It sits between the pad-side serial input and any byte consumer, such as a FIFO or a bus register block.

## Interface
- `CLK_FREQ`, 50000000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in bit/s
- `DATA_BITS`, 8, character width; legal values 5..9
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even
- `STOP_BITS`, 1, stop bits checked; legal values 1 or 2

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset)
- `rx`  in  1  asynchronous serial input, idle high
- `rx_data`  out  DATA_BITS  held character, LSB = first bit received
- `rx_valid`  out  1  holding register full
- `rx_ready`  in  1  consumer accepts the held character when `rx_valid & rx_ready`
- `parity_err`  out  1  held character failed the parity check (always 0 when PARITY=0)
- `frame_err`  out  1  held character had a stop bit sampled as 0
- `break_det`  out  1  held character is a break
- `overrun`  out  1  sticky: a character was lost because the holding register was full
- `overrun_clr`  in  1  one-cycle pulse that clears `overrun`

## Operation
- Input: a 2-FF synchronizer on `rx` produces `rx_s`. Both flops reset to 1.
- Tick generator: `DIV = CLK_FREQ/(BAUD_RATE*16)`, truncated, minimum 1. At the defaults DIV = 27. One `tick` pulse every DIV clocks. The generator is held cleared in IDLE and restarts on start detect.
- Bit timing: a 4-bit sample counter `s` counts ticks 0..15 per bit. The bit value is the majority of `rx_s` at s = 7, 8 and 9, decided at s = 9.
- FSM states: IDLE, START, DATA, PAR, STOP, BRKWAIT.
  - IDLE: when `rx_s` = 0, clear the divider and `s`, then go to START.
  - START: if the vote is 1, this is a glitch; return to IDLE with no output. Otherwise go to DATA at s = 15.
  - DATA: shift in DATA_BITS votes, LSB first. After the last bit at s = 15, go to PAR if PARITY != 0, else STOP.
  - PAR: compute the expected parity. Odd means data plus parity has an odd count of 1s; even means an even count. At s = 15, go to STOP.
  - STOP: check STOP_BITS bits. Any stop vote of 0 sets the frame error. The character completes at s = 9 of the last stop bit and does not wait for s = 15, which allows early resynchronisation. The FSM then goes to IDLE, or to BRKWAIT on a break.
  - BRKWAIT: wait for `rx_s` = 1, then go to IDLE.
- Break definition: all data votes are 0, the parity vote (if present) is 0, and the first stop vote is 0. The character is published as data 0 with `break_det` = 1 and `frame_err` = 1. Exactly one character is published per break.
- Publish rules:
  - Holding register empty: load `rx_data` and the three error flags, and set `rx_valid`.
  - Holding register full and accepted (`rx_valid & rx_ready`) in the same cycle: load the new character and keep `rx_valid` = 1.
  - Holding register full and not accepted: discard the new character, set `overrun`, and keep the held character.
- Accept: `rx_valid & rx_ready` with no completion in that cycle clears `rx_valid` at the next edge. `rx_data` and the flags hold their last value, but are meaningful only while `rx_valid` = 1.
- `overrun` is cleared by `overrun_clr`. If a set and a clear occur in the same cycle, the set wins.
- Reset mid-frame: the FSM returns to IDLE immediately and any partial character is dropped.

## Timing
- Reset values: `rx_data` = 0; `rx_valid`, `parity_err`, `frame_err`, `break_det` and `overrun` = 0; FSM in IDLE.
- Start detect: IDLE leaves on the second clock after the `rx` falling edge, because of the synchronizer.
- Publish latency: `rx_valid` rises one clock after the tick at s = 9 of the last stop bit. The clock edge to publish count is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS − 1)·16 + 10 ticks, plus about 3 clocks.
- Defaults: one bit = 16·27 = 432 clocks = 8640 ns.
- Throughput: back-to-back frames with no idle time between them are received without loss, provided each character is accepted before the next one completes.

## Test plan
- Default 8N1: send 0x55, then 0xA3 back to back, with `rx_ready` = 1. Expect `rx_data` = 0x55 then 0xA3, one `rx_valid` pulse each, and all error flags 0.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2: send 0x41 with correct parity (bit 0), then with the wrong parity bit. Expect `parity_err` = 0, then `parity_err` = 1 with `rx_data` = 0x41.
- Framing: 8N1, send 0x3C with the stop bit driven 0. Expect `rx_data` = 0x3C, `frame_err` = 1, `break_det` = 0.
- Break: hold `rx` low for 20 bit times, then release. Expect exactly one character with `rx_data` = 0x00, `break_det` = 1 and `frame_err` = 1. The next 0x5A sent after release is received cleanly.
- Glitch and reset: a 100-clock low pulse on idle `rx` gives no `rx_valid`. Asserting `rst` = 0 in the middle of a 0x77 frame clears every output to 0. A subsequent 0x77 is then received correctly.
- Overrun: with `rx_ready` = 0, send 0x11 then 0x22. Expect `rx_data` = 0x11 and `overrun` = 1 after the second character. A pulse on `overrun_clr` returns `overrun` to 0. Raising `rx_ready` clears `rx_valid`.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 16x oversampling, 3-sample majority vote, parity/framing/break
// detection, and a valid/ready holding register with a sticky overrun flag.
module uart_rx_cfg #(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD_RATE = 115200,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun,
   input  logic                 overrun_clr
);

   localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
   localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
   localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StStart   = 3'd1;
   localparam logic [2:0] StData    = 3'd2;
   localparam logic [2:0] StPar     = 3'd3;
   localparam logic [2:0] StStop    = 3'd4;
   localparam logic [2:0] StBrkWait = 3'd5;

   logic [1:0]           r_sync;
   logic [2:0]           r_state;
   logic [DIV_W-1:0]     r_div;
   logic [3:0]           r_s;
   logic [1:0]           r_smp;
   logic [3:0]           r_bit_cnt;
   logic                 r_stop_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bit;
   logic                 r_frame;
   logic                 r_brk_cand;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_valid;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 r_brk;
   logic                 r_overrun;

   logic w_rx_s;
   logic w_tick;
   logic w_mid;
   logic w_end;
   logic w_vote;
   logic w_last_stop;
   logic w_done;
   logic w_brk;
   logic w_ferr;
   logic w_ones_odd;
   logic w_perr;

   assign w_rx_s      = r_sync[1];
   assign w_tick      = (r_state != StIdle) && (r_div == DIV_W'(DIV - 1));
   assign w_mid       = w_tick && (r_s == 4'd9);
   assign w_end       = w_tick && (r_s == 4'd15);
   assign w_vote      = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx_s) | (r_smp[1] & w_rx_s);
   assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
   assign w_done      = (r_state == StStop) && w_mid && w_last_stop;
   // The first stop vote is live during stop bit 0 and folded into r_brk_cand afterwards.
   assign w_brk       = r_brk_cand & (r_stop_cnt | ~w_vote);
   assign w_ferr      = r_frame | ~w_vote | w_brk;
   assign w_ones_odd  = (^r_shift) ^ r_par_bit;
   assign w_perr      = (PARITY == 1) ? ~w_ones_odd : (PARITY == 2) ? w_ones_odd : 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_sync <= 2'b11;
      else      r_sync <= {r_sync[0], rx};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div <= '0;
         r_s   <= '0;
         r_smp <= 2'b11;
      end else begin
         if (r_state == StIdle) begin
            r_div <= '0;
            r_s   <= '0;
         end else if (w_tick) begin
            r_div <= '0;
            r_s   <= r_s + 4'd1;
         end else begin
            r_div <= r_div + 1'b1;
         end
         if (w_tick && r_s == 4'd7) r_smp[0] <= w_rx_s;
         if (w_tick && r_s == 4'd8) r_smp[1] <= w_rx_s;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= StIdle;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_shift    <= '0;
         r_par_bit  <= 1'b0;
         r_frame    <= 1'b0;
         r_brk_cand <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_bit_cnt  <= '0;
               r_stop_cnt <= 1'b0;
               r_frame    <= 1'b0;
               r_brk_cand <= 1'b1;
               r_par_bit  <= 1'b0;
               if (!w_rx_s) r_state <= StStart;
            end
            StStart: begin
               if (w_mid && w_vote) r_state <= StIdle;
               else if (w_end)      r_state <= StData;
            end
            StData: begin
               if (w_mid) begin
                  r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                  if (w_vote) r_brk_cand <= 1'b0;
               end
               if (w_end) begin
                  if (r_bit_cnt == 4'(DATA_BITS - 1)) r_state <= (PARITY != 0) ? StPar : StStop;
                  else r_bit_cnt <= r_bit_cnt + 4'd1;
               end
            end
            StPar: begin
               if (w_mid) begin
                  r_par_bit <= w_vote;
                  if (w_vote) r_brk_cand <= 1'b0;
               end
               if (w_end) r_state <= StStop;
            end
            StStop: begin
               if (w_mid) begin
                  if (!w_vote) r_frame <= 1'b1;
                  if (!r_stop_cnt) r_brk_cand <= r_brk_cand & ~w_vote;
                  // Finish mid-stop-bit so the next start edge is never missed.
                  if (w_last_stop) r_state <= w_brk ? StBrkWait : StIdle;
               end else if (w_end) begin
                  r_stop_cnt <= 1'b1;
               end
            end
            StBrkWait: begin
               if (w_rx_s) r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_data <= '0;
         r_valid   <= 1'b0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
         r_brk     <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_done && (!r_valid || rx_ready)) begin
            r_rx_data <= w_brk ? '0 : r_shift;
            r_perr    <= w_perr;
            r_ferr    <= w_ferr;
            r_brk     <= w_brk;
            r_valid   <= 1'b1;
         end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end
         if (w_done && r_valid && !rx_ready) r_overrun <= 1'b1;
         else if (overrun_clr)                r_overrun <= 1'b0;
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_valid;
   assign parity_err = r_perr;
   assign frame_err  = r_ferr;
   assign break_det  = r_brk;
   assign overrun    = r_overrun;

endmodule
